// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Parity selection and transmit FSM state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time tick generator for the UART transmitter.
// Wraps at CLKS_PER_BIT-1; clr realigns timing to a new frame.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_t,
    input  logic srst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // count clk_t cycles within the current bit, restart on clr or wrap
    always_ff @(posedge clk_t or negedge srst_n) begin
        if (!srst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, data LSB first,
// optional parity, one or two stop bits; registered tx.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int      DATA_W       = 8,
    parameter int      CLKS_PER_BIT = 16,
    parameter parity_e PARITY_MODE  = PAR_EVEN,
    parameter int      STOP_BITS    = 1
) (
    input  logic              clk_t,
    input  logic              srst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_cfg: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_e         state, state_d;
    logic [DATA_W-1:0] sreg, sreg_d;
    logic [3:0]        bcnt, bcnt_d;
    logic              par, par_d;
    logic              tx_d;
    logic              live;
    logic              tick;
    logic              accept;
    logic              last_stop;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_t (clk_t),
        .srst_n(srst_n),
        .clr   (accept),
        .tick  (tick)
    );

    assign last_stop = (state == STOP) && tick &&
                       (bcnt == 4'(STOP_BITS - 1));
    assign tx_ready  = live && ((state == IDLE) || last_stop);
    assign accept    = tx_valid && tx_ready;
    assign tx_done   = last_stop;
    assign busy      = (state != IDLE);

    // hold tx_ready low until the first edge after reset release
    always_ff @(posedge clk_t or negedge srst_n) begin
        if (!srst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // next state, shift register, bit counter and next line level
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        bcnt_d  = bcnt;
        par_d   = par;
        if (accept) begin
            sreg_d = tx_data;
            par_d  = (^tx_data) ^ (PARITY_MODE == PAR_ODD);
        end
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    bcnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bcnt == 4'(DATA_W - 1)) begin
                        state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt + 4'd1;
                        sreg_d = sreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    bcnt_d  = '0;
                end
            end
            STOP: begin
                if (last_stop) begin
                    state_d = accept ? START : IDLE;
                    bcnt_d  = '0;
                end else if (tick) begin
                    bcnt_d = bcnt + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // frame state registers; reset abandons any frame in flight
    always_ff @(posedge clk_t or negedge srst_n) begin
        if (!srst_n) begin
            state <= IDLE;
            sreg  <= '0;
            bcnt  <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_d;
            sreg  <= sreg_d;
            bcnt  <= bcnt_d;
            par   <= par_d;
            tx    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three configurations,
// expected frames queued by stimulus, checked by a line monitor.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        bit          b2b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] txw;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [8:0] dat [3];
    int         cur;
    int         tests;
    int         fails;
    exp_t       q[$];
    logic       txm, rdym, donem;

    assign txm   = txw[cur];
    assign rdym  = rdy[cur];
    assign donem = dn[cur];

    uart_tx_cfg #(
        .DATA_W(8), .CLKS_PER_BIT(4),
        .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)
    ) u_a (
        .clk_t(clk), .srst_n(rst_n),
        .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx(txw[0]),
        .busy(bsy[0]), .tx_done(dn[0])
    );

    uart_tx_cfg #(
        .DATA_W(8), .CLKS_PER_BIT(4),
        .PARITY_MODE(PAR_ODD), .STOP_BITS(1)
    ) u_b (
        .clk_t(clk), .srst_n(rst_n),
        .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .tx(txw[1]),
        .busy(bsy[1]), .tx_done(dn[1])
    );

    uart_tx_cfg #(
        .DATA_W(7), .CLKS_PER_BIT(4),
        .PARITY_MODE(PAR_NONE), .STOP_BITS(2)
    ) u_c (
        .clk_t(clk), .srst_n(rst_n),
        .tx_valid(vld[2]), .tx_data(dat[2][6:0]),
        .tx_ready(rdy[2]), .tx(txw[2]),
        .busy(bsy[2]), .tx_done(dn[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input int k, input logic [8:0] d,
                        input logic [15:0] bits, input int nb,
                        input bit b2b);
        int n;
        exp_t e;
        e.bits = bits;
        e.nb   = nb;
        e.b2b  = b2b;
        q.push_back(e);
        dat[k] = d;
        vld[k] = 1'b1;
        n = 0;
        while (!rdy[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_timeout", 16'd1, 16'd0);
        @(posedge clk);
        #1 vld[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (bsy[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 16'd1, 16'd0);
        @(negedge clk);
    endtask

    // monitor: decode each frame on the selected line against the queue
    initial begin
        int   idle;
        exp_t e;
        logic [15:0] obs;
        bit   bok, dok, rok, ab;
        idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idle = 0;
                continue;
            end
            if (txm === 1'b1) begin
                idle++;
                continue;
            end
            if (q.size() == 0) begin
                check("unexpected_frame", 16'd1, 16'd0);
                while (txm !== 1'b1 && rst_n) @(negedge clk);
                idle = 0;
                continue;
            end
            e = q.pop_front();
            obs = '0;
            bok = 1;
            dok = 1;
            rok = 1;
            ab  = 0;
            for (int i = 0; i < e.nb * 4; i++) begin
                if (i > 0) @(negedge clk);
                if (!rst_n) begin
                    ab = 1;
                    break;
                end
                if (i % 4 == 1) obs[i/4] = txm;
                if (txm !== e.bits[i/4]) bok = 0;
                if (donem !== (i == e.nb * 4 - 1)) dok = 0;
                if (rdym !== (i == e.nb * 4 - 1)) rok = 0;
            end
            if (!ab) begin
                check("frame_bits", bok ? e.bits : obs, e.bits);
                check("tx_done_timing", 16'(dok), 16'd1);
                check("tx_ready_once", 16'(rok), 16'd1);
                if (e.b2b) check("b2b_gap", 16'(idle), 16'd0);
            end
            idle = 0;
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        cur   = 0;
        vld   = '0;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("reset_state",
                  16'({txw[k], bsy[k], dn[k], rdy[k]}), 16'b1000);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("ready_after_reset", 16'(rdy[k]), 16'd1);

        send(0, 9'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0);
        wait_idle(0);
        send(0, 9'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 11, 0);
        send(0, 9'hAA, {1'b1, 1'b0, 8'hAA, 1'b0}, 11, 1);
        wait_idle(0);

        send(0, 9'hF0, {1'b1, 1'b0, 8'hF0, 1'b0}, 11, 0);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset",
              16'({txw[0], bsy[0], dn[0], rdy[0]}), 16'b1000);
        repeat (2) @(negedge clk);
        check("reset_no_done", 16'(dn[0]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 9'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 0);
        wait_idle(0);

        send(0, 9'h81, {1'b1, 1'b0, 8'h81, 1'b0}, 11, 0);
        repeat (10) @(negedge clk);
        dat[0] = 9'hFF;
        vld[0] = 1'b1;
        check("busy_ready_low", 16'(rdy[0]), 16'd0);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        check("pulse_ignored", 16'(bsy[0]), 16'd0);
        send(0, 9'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
        wait_idle(0);

        cur = 1;
        send(1, 9'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 11, 0);
        wait_idle(1);
        send(1, 9'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11, 0);
        wait_idle(1);

        cur = 2;
        send(2, 9'h07F, {2'b11, 7'h7F, 1'b0}, 10, 0);
        wait_idle(2);

        repeat (4) @(negedge clk);
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16, clk_t cycles per serial bit, legal range 2..65535.
REQ-003 SHALL provide parameter PARITY_MODE, default PAR_EVEN, one of PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 clk_t  input  1  single clock; all logic on rising edge.
REQ-006 srst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tx_valid  input  1  word offered for transmission.
REQ-008 tx_data  input  DATA_W  word to send, LSB first.
REQ-009 tx_ready  output  1  block can accept a word this cycle.
REQ-010 tx  output  1  serial line, idle high; registered.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 tx_done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-013 Frame SHALL be sent in this order: start bit (0), then DATA_W data bits LSB first, then a parity bit if PARITY_MODE != PAR_NONE, then STOP_BITS stop bits (1).
REQ-014 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, so a frame lasts (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P is 0 or 1.
REQ-015 Parity SHALL be XOR of the captured data for PAR_EVEN and its inverse for PAR_ODD.
REQ-016 A word SHALL be accepted on any cycle where tx_valid && tx_ready; tx_data is captured into an internal shift register at that edge.
REQ-017 Changes on tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-018 tx SHALL drive the start bit starting from the cycle after acceptance (1-cycle latency).
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 FSM transitions: IDLE->START on accept; START->DATA after one bit time; DATA->PARITY (or ->STOP if PAR_NONE) after DATA_W bit times; PARITY->STOP after one bit time; STOP->IDLE after STOP_BITS bit times.
REQ-021 An internal bit counter SHALL count data and stop bits and SHALL be cleared on each state entry.
REQ-022 tx_ready SHALL be high in IDLE and in the final clk_t cycle of the last stop bit; it SHALL be low at all other times.
REQ-023 Back-to-back: accepting a word in the final stop cycle SHALL go STOP->START directly with no idle cycle, and tx_done SHALL still pulse for the completed frame.
REQ-024 tx_valid while tx_ready is low SHALL be ignored, with no data loss or state change; the sender holds tx_valid until accepted.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 The baud counter SHALL wrap from CLKS_PER_BIT-1 to 0, generating a one-cycle bit tick; it SHALL be cleared on accept so that bit timing aligns to acceptance.

Reset
REQ-027 While srst_n is low: tx=1, busy=0, tx_done=0, tx_ready=0, state=IDLE, and all counters and the shift register are 0.
REQ-028 tx_ready SHALL go high in the first cycle after srst_n deasserts.
REQ-029 Reset mid-frame SHALL abandon the frame immediately: tx returns high asynchronously and no tx_done is produced.

Structure
REQ-030 Package uart_pkg SHALL hold the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx_state_e typedef.
REQ-031 The baud tick counter SHALL be a sub-module, uart_baud_gen (parameter CLKS_PER_BIT; ports clk_t, srst_n, clr, tick).
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-033 DATA_W=8, CLKS_PER_BIT=4, PAR_EVEN, STOP_BITS=1; send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; tx_done pulses 44 cycles after accept.
REQ-034 Same configuration with PAR_ODD, send 0x01 -> parity bit 0; send 0x00 -> parity bit 1.
REQ-035 PAR_NONE, STOP_BITS=2, DATA_W=7, send 0x7F -> frame of 10 bits (40 cycles), final 8 cycles high, no parity slot.
REQ-036 Hold tx_valid high with 0x55 then 0xAA -> second start bit immediately follows the first stop bit with zero idle cycles; tx_ready is high in exactly one cycle per frame.
REQ-037 Assert srst_n low at bit 4 of a frame -> tx=1 and busy=0 in the same cycle, no tx_done; a new word sent after reset is transmitted correctly.
REQ-038 Change tx_data and pulse tx_valid mid-frame -> transmitted bits unchanged and the word is not accepted until tx_ready is high.
